clock_period_meter: RTL

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

---
 rtl/clock_period_meter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/clock_period_meter.sv
// Measures the period and high time of an asynchronous clock in clk_in cycles,
// with lock and stop detection. Define CLK_METER_DUTY_EN to build the high-time counter.
module clock_period_meter #(
  parameter int CNT_W       = 16,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_meas,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MC_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);
  localparam logic [MC_W-1:0]  MC_MAX = MC_W'(LOCK_COUNT);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state;
  logic             sync1, lvl, lvl_d;
  logic             rise;
  logic [CNT_W-1:0] pcnt;
  logic [MC_W-1:0]  mcnt, mcnt_nxt;
  logic             have_prev;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      sync1 <= clk_meas;
      lvl   <= sync1;
      lvl_d <= lvl;
    end
  end

  assign rise = lvl & ~lvl_d;

  // First result after IDLE has no predecessor and always counts as a mismatch.
  always_comb begin
    mcnt_nxt = '0;
    if (have_prev && (pcnt == period))
      mcnt_nxt = (mcnt == MC_MAX) ? mcnt : mcnt + MC_W'(1);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pcnt       <= '0;
      mcnt       <= '0;
      have_prev  <= 1'b0;
      period     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state     <= MEASURE;
            pcnt      <= CNT_W'(1);
            timeout   <= 1'b0;
            have_prev <= 1'b0;
          end
        end
        MEASURE: begin
          // An edge on the threshold cycle wins over the timeout.
          if (rise) begin
            period     <= pcnt;
            meas_valid <= 1'b1;
            pcnt       <= CNT_W'(1);
            have_prev  <= 1'b1;
            mcnt       <= mcnt_nxt;
            locked     <= (mcnt_nxt == MC_MAX);
          end else if (pcnt == TO_LIM) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
            mcnt    <= '0;
            state   <= IDLE;
          end else begin
            pcnt <= pcnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLK_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] high_r;

  // Tracks pcnt's load/capture points; never exceeds pcnt, so it cannot wrap.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hcnt   <= '0;
      high_r <= '0;
    end else if (state == IDLE) begin
      if (rise) hcnt <= CNT_W'(1);
    end else if (rise) begin
      high_r <= hcnt;
      hcnt   <= CNT_W'(1);
    end else if (pcnt != TO_LIM && lvl) begin
      hcnt <= hcnt + CNT_W'(1);
    end
  end

  assign high_time = high_r;
`else
  assign high_time = '0;
`endif

endmodule
